stepper_motor_ctrl: RTL and testbench

- Parametrised successor to the existing 2-bit stepper driver.
- Drives a 4-coil unipolar stepper through a phase table, with a programmable step period, selectable full/half-step mode, direction, a move-length counter and a signed position tracker.
- Sits between the control FSM (start/abort/move length) and the coil driver pins.
- Runs one move per start pulse and reports busy/done.

---
 rtl/stepper_if.sv | 25 ++
 rtl/stepper_motor_ctrl.sv | 75 +++++++
 tb/tb_stepper_motor_ctrl.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/stepper_if.sv
// stepper_if: control/status bundle between the move controller and the stepper driver
interface stepper_if #(
  parameter int DIV_W = 16,
  parameter int CNT_W = 16,
  parameter int POS_W = 24
);
  logic             start;
  logic             abort;
  logic             direction;
  logic             half_step;
  logic [CNT_W-1:0] step_count;
  logic [DIV_W-1:0] period;
  logic [3:0]       coil;
  logic             busy;
  logic             done;
  logic [POS_W-1:0] position;
  modport master (
    output start, abort, direction, half_step, step_count, period,
    input  coil, busy, done, position
  );
  modport slave (
    input  start, abort, direction, half_step, step_count, period,
    output coil, busy, done, position
  );
endinterface

// File: rtl/stepper_motor_ctrl.sv
// stepper_motor_ctrl: 4-coil unipolar stepper sequencer with move length, period and position tracking.
// HOLD_TORQUE_EN keeps the coils energised on the current phase while idle.
module stepper_motor_ctrl #(
  parameter int DIV_W = 16,
  parameter int CNT_W = 16,
  parameter int POS_W = 24
) (
  input  logic clk_in,
  input  logic reset,
  stepper_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam logic [3:0] PHASES [8] = '{4'b1000, 4'b1100, 4'b0100, 4'b0110,
                                        4'b0010, 4'b0011, 4'b0001, 4'b1001};
  state_t state, state_nx;
  logic [DIV_W-1:0] per_q, tick;
  logic [CNT_W-1:0] cnt_q, steps;
  logic dir_q, half_q, step;
  logic [2:0] idx, inc;
  logic [POS_W-1:0] pos, delta;
  logic [3:0] coil_q;
  assign step  = state == RUN && !bus.abort && tick == per_q - DIV_W'(1);
  assign inc   = half_q ? 3'd1 : 3'd2;
  assign delta = half_q ? POS_W'(1) : POS_W'(2);
  always_comb begin
    state_nx = state == DONE ? IDLE
             : state == IDLE ? (bus.start ? (bus.step_count == '0 ? DONE : RUN) : IDLE)
             : (bus.abort || (step && steps + CNT_W'(1) == cnt_q)) ? DONE : RUN;
  end
  always_ff @(posedge clk_in) begin
    if (reset) begin
      state  <= IDLE;
      idx    <= '0;
      pos    <= '0;
      tick   <= '0;
      steps  <= '0;
      per_q  <= DIV_W'(1);
      cnt_q  <= '0;
      dir_q  <= 1'b0;
      half_q <= 1'b0;
`ifdef HOLD_TORQUE_EN
      coil_q <= 4'b1000;
`else
      coil_q <= 4'b0000;
`endif
    end else begin
      state <= state_nx;
      if (state == IDLE && bus.start) begin
        dir_q  <= bus.direction;
        half_q <= bus.half_step;
        cnt_q  <= bus.step_count;
        per_q  <= bus.period == '0 ? DIV_W'(1) : bus.period;
        tick   <= '0;
        steps  <= '0;
      end else if (step) begin
        idx   <= dir_q ? idx + inc : idx - inc;
        pos   <= dir_q ? pos + delta : pos - delta;
        steps <= steps + CNT_W'(1);
        tick  <= '0;
      end else if (state == RUN) begin
        tick <= tick + DIV_W'(1);
      end
`ifdef HOLD_TORQUE_EN
      coil_q <= PHASES[idx];
`else
      // the DONE cycle after a real move still shows the final phase before de-energising
      coil_q <= (state == RUN || (state == DONE && cnt_q != '0)) ? PHASES[idx] : 4'b0000;
`endif
    end
  end
  assign bus.coil     = coil_q;
  assign bus.busy     = state == RUN;
  assign bus.done     = state == DONE;
  assign bus.position = pos;
endmodule

// File: tb/tb_stepper_motor_ctrl.sv
// tb_stepper_motor_ctrl: directed-vector bench for stepper_motor_ctrl.
module tb_stepper_motor_ctrl;
  logic clk_in = 1'b0;
  logic reset  = 1'b1;
  int pass  = 0;
  int total = 0;
  stepper_if #(.DIV_W(16), .CNT_W(16), .POS_W(24)) bus ();
  stepper_motor_ctrl #(.DIV_W(16), .CNT_W(16), .POS_W(24)) dut (
    .clk_in(clk_in), .reset(reset), .bus(bus)
  );
  always #5 clk_in = ~clk_in;
`ifdef HOLD_TORQUE_EN
  localparam logic HOLD = 1'b1;
  localparam logic [3:0] RST_COIL = 4'b1000;
`else
  localparam logic HOLD = 1'b0;
  localparam logic [3:0] RST_COIL = 4'b0000;
`endif
  task automatic cyc(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask
  task automatic do_reset();
    reset = 1'b1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    cyc(1);
    reset = 1'b0;
  endtask
  task automatic go(input logic d, input logic h, input logic [15:0] c, input logic [15:0] p);
    bus.direction  = d;
    bus.half_step  = h;
    bus.step_count = c;
    bus.period     = p;
    bus.start      = 1'b1;
    cyc(1);
    bus.start = 1'b0;
  endtask
  task automatic test_reset();
    do_reset();
    total++; if (bus.coil !== RST_COIL) $display("FAIL rst_coil got %b exp %b", bus.coil, RST_COIL); else pass++;
    total++; if (bus.busy !== 1'b0) $display("FAIL rst_busy got %b exp 0", bus.busy); else pass++;
    total++; if (bus.done !== 1'b0) $display("FAIL rst_done got %b exp 0", bus.done); else pass++;
    total++; if (bus.position !== 24'd0) $display("FAIL rst_pos got %0h exp 0", bus.position); else pass++;
  endtask
  task automatic test_half_forward();
    logic [3:0] e;
    int dones = 0;
    go(1'b1, 1'b1, 16'd3, 16'd4);
    total++; if (bus.busy !== 1'b1) $display("FAIL hf_busy0 got %b exp 1", bus.busy); else pass++;
    for (int k = 1; k <= 14; k++) begin
      cyc(1);
      e = k <= 4 ? 4'b1000 : k <= 8 ? 4'b1100 : k <= 12 ? 4'b0100 : k == 13 ? 4'b0110
        : (HOLD ? 4'b0110 : 4'b0000);
      if (bus.done === 1'b1) dones++;
      total++; if (bus.coil !== e) $display("FAIL hf_coil k=%0d got %b exp %b", k, bus.coil, e); else pass++;
      total++; if (bus.busy !== (k < 12)) $display("FAIL hf_busy k=%0d got %b exp %b", k, bus.busy, k < 12); else pass++;
    end
    total++; if (dones != 1) $display("FAIL hf_done_count got %0d exp 1", dones); else pass++;
    total++; if (bus.position !== 24'd3) $display("FAIL hf_pos got %0h exp 3", bus.position); else pass++;
  endtask
  task automatic test_full_reverse();
    do_reset();
    go(1'b0, 1'b0, 16'd2, 16'd2);
    cyc(2);
    total++; if (bus.coil !== 4'b1000) $display("FAIL fr_coil2 got %b exp 1000", bus.coil); else pass++;
    cyc(1);
    total++; if (bus.coil !== 4'b0001) $display("FAIL fr_coil3 got %b exp 0001", bus.coil); else pass++;
    cyc(1);
    total++; if (bus.done !== 1'b1) $display("FAIL fr_done got %b exp 1", bus.done); else pass++;
    total++; if (bus.position !== 24'hFFFFFC) $display("FAIL fr_pos got %0h exp fffffc", bus.position); else pass++;
    cyc(1);
    total++; if (bus.coil !== 4'b0010) $display("FAIL fr_coil5 got %b exp 0010", bus.coil); else pass++;
    cyc(1);
  endtask
  task automatic test_zero_and_degenerate();
    logic [3:0] idle_c;
    idle_c = HOLD ? 4'b0010 : 4'b0000;
    go(1'b1, 1'b1, 16'd0, 16'd5);
    total++; if (bus.done !== 1'b1) $display("FAIL z_done got %b exp 1", bus.done); else pass++;
    total++; if (bus.busy !== 1'b0) $display("FAIL z_busy0 got %b exp 0", bus.busy); else pass++;
    total++; if (bus.coil !== idle_c) $display("FAIL z_coil0 got %b exp %b", bus.coil, idle_c); else pass++;
    cyc(1);
    total++; if (bus.done !== 1'b0) $display("FAIL z_done1 got %b exp 0", bus.done); else pass++;
    total++; if (bus.busy !== 1'b0) $display("FAIL z_busy1 got %b exp 0", bus.busy); else pass++;
    total++; if (bus.coil !== idle_c) $display("FAIL z_coil1 got %b exp %b", bus.coil, idle_c); else pass++;
    do_reset();
    go(1'b1, 1'b1, 16'd2, 16'd0);
    cyc(1);
    total++; if (bus.position !== 24'd1) $display("FAIL p0_pos1 got %0h exp 1", bus.position); else pass++;
    cyc(1);
    total++; if (bus.position !== 24'd2) $display("FAIL p0_pos2 got %0h exp 2", bus.position); else pass++;
    total++; if (bus.done !== 1'b1) $display("FAIL p0_done got %b exp 1", bus.done); else pass++;
    total++; if (bus.coil !== 4'b1100) $display("FAIL p0_coil got %b exp 1100", bus.coil); else pass++;
    cyc(1);
  endtask
  task automatic test_abort();
    do_reset();
    go(1'b1, 1'b1, 16'd10, 16'd3);
    cyc(8);
    total++; if (bus.position !== 24'd2) $display("FAIL ab_pre_pos got %0h exp 2", bus.position); else pass++;
    bus.abort = 1'b1;
    cyc(1);
    bus.abort = 1'b0;
    total++; if (bus.done !== 1'b1) $display("FAIL ab_done got %b exp 1", bus.done); else pass++;
    total++; if (bus.busy !== 1'b0) $display("FAIL ab_busy got %b exp 0", bus.busy); else pass++;
    total++; if (bus.position !== 24'd2) $display("FAIL ab_pos got %0h exp 2", bus.position); else pass++;
    cyc(1);
    total++; if (bus.coil !== 4'b0100) $display("FAIL ab_coil got %b exp 0100", bus.coil); else pass++;
    total++; if (bus.done !== 1'b0) $display("FAIL ab_done1 got %b exp 0", bus.done); else pass++;
    go(1'b1, 1'b1, 16'd1, 16'd1);
    cyc(1);
    total++; if (bus.position !== 24'd3) $display("FAIL ab_restart_pos got %0h exp 3", bus.position); else pass++;
    total++; if (bus.done !== 1'b1) $display("FAIL ab_restart_done got %b exp 1", bus.done); else pass++;
    cyc(1);
  endtask
  task automatic test_ignored_start_and_reset();
    do_reset();
    go(1'b1, 1'b1, 16'd3, 16'd2);
    cyc(2);
    bus.step_count = 16'd1;
    bus.start = 1'b1;
    cyc(1);
    bus.start = 1'b0;
    total++; if (bus.busy !== 1'b1) $display("FAIL ig_busy got %b exp 1", bus.busy); else pass++;
    cyc(3);
    total++; if (bus.done !== 1'b1) $display("FAIL ig_done got %b exp 1", bus.done); else pass++;
    total++; if (bus.position !== 24'd3) $display("FAIL ig_pos got %0h exp 3", bus.position); else pass++;
    cyc(1);
    go(1'b1, 1'b1, 16'd5, 16'd2);
    cyc(2);
    total++; if (bus.position !== 24'd4) $display("FAIL mr_pre_pos got %0h exp 4", bus.position); else pass++;
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    total++; if (bus.busy !== 1'b0) $display("FAIL mr_busy got %b exp 0", bus.busy); else pass++;
    total++; if (bus.done !== 1'b0) $display("FAIL mr_done got %b exp 0", bus.done); else pass++;
    total++; if (bus.position !== 24'd0) $display("FAIL mr_pos got %0h exp 0", bus.position); else pass++;
    total++; if (bus.coil !== RST_COIL) $display("FAIL mr_coil got %b exp %b", bus.coil, RST_COIL); else pass++;
    cyc(1);
    total++; if (bus.done !== 1'b0) $display("FAIL mr_done1 got %b exp 0", bus.done); else pass++;
  endtask
  initial begin
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.direction = 1'b0;
    bus.half_step = 1'b0;
    bus.step_count = '0;
    bus.period = '0;
    test_reset();
    test_half_forward();
    test_full_reverse();
    test_zero_and_degenerate();
    test_abort();
    test_ignored_start_and_reset();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
